pwm_duty_ramp: RTL and testbench
================================

Name: pwm_duty_ramp

Overview:
- Upstream duty-cycle sequencer for the pwm generator. It produces the pwm `duty` word and ramps it toward a loaded target in fixed steps, giving soft-start and fade behaviour.
- It keeps its own period counter, aligned to the pwm period, and changes `duty` only on period boundaries. The pwm stage therefore never sees a duty change mid-period.
- Used for LED fades and motor soft-start on the BASYS 100 MHz clock.

Parameters:
- WIDTH, 17, bit width of duty/target; must match the downstream pwm WIDTH.
- PERIOD, 100000, clocks per pwm period (1 ms at 100 MHz); must match the downstream pwm period.
- STEP, 1000, duty increment/decrement applied per ramp step.
- PERIODS_PER_STEP, 1, pwm periods between ramp steps (>=1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- target, input, WIDTH, requested final duty; sampled when load=1.
- load, input, 1, one-cycle strobe; captures target.
- duty, output, WIDTH, registered duty word to the pwm stage.
- period_tick, output, 1, one-cycle pulse on the last clock of each period (period counter == PERIOD-1).
- busy, output, 1, high while duty != captured target.
- done, output, 1, one-cycle pulse when duty reaches target.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: duty=0, busy=0, done=0, period_tick=0.
  - Internal: period counter=0, step counter=0, captured target=0, state=IDLE.
  - Release is synchronous to the next clk edge.
- Period counter:
  - Free-runs 0..PERIOD-1 and wraps to 0.
  - period_tick is registered and high for exactly one cycle per period.
  - load does not reset the period counter.
- Target capture on load:
  - tgt = min(target, PERIOD); values above PERIOD are clamped.
  - Step counter is cleared.
  - State is set to UP if tgt>duty, DOWN if tgt<duty, IDLE if equal.
  - If equal: busy stays 0 and done pulses the following cycle.
  - A load during UP/DOWN replaces the target and re-evaluates direction. duty holds its current value; there is no jump.
- States:
  - IDLE: duty held, busy=0.
  - UP: on each period_tick, step counter increments. When it equals PERIODS_PER_STEP-1, it clears and a step occurs.
    - Step: duty = (duty+STEP >= tgt) ? tgt : duty+STEP.
    - Sum is computed in WIDTH+1 bits, so there is no overflow or overshoot.
  - DOWN: same step timing.
    - Step: duty = (duty-tgt <= STEP) ? tgt : duty-STEP.
    - There is no underflow below tgt or 0.
  - On the step that makes duty==tgt: go to IDLE, busy falls, done=1 for one cycle (same edge duty updates).
- busy is a registered output, asserted the cycle after a load whose tgt != duty.
- Latency: duty changes on the clock edge following the period_tick cycle that completes a step. duty is therefore stable for the whole of the next period.
- load and period_tick in the same cycle: load wins. Target is captured, step counter is cleared, and no step occurs on that tick.
- duty, busy, done and period_tick are all driven from flops; there are no combinational outputs.
- Reset mid-ramp: duty goes to 0 immediately (async), state IDLE, no done pulse.

Test Plan:
Bench parameters for all scenarios: WIDTH=8, PERIOD=100, STEP=30, PERIODS_PER_STEP=2, clk period 10 ns.
- Reset → all outputs 0 while rst_n=0. After release, period_tick pulses every 100 clocks, first at clock 99.
- Ramp up: load target=100 from duty=0.
  - Steps occur on the 2nd/4th/6th/8th period_tick after load.
  - duty sequence is 30,60,90,100.
  - done pulses once with duty=100; busy is high from load+1 until that edge.
- Clamp and ramp down:
  - load target=150 → captured 100, same sequence as ramp up.
  - Then load target=0 → duty 70,40,10,0, then done; duty never wraps.
- Reversal and collision:
  - Mid-ramp at duty=60 (UP to 100), load target=20 coincident with period_tick. No step on that tick; duty stays 60.
  - Then 2 ticks later → 30, then 20, done.
- No-op load: load target equal to current duty → busy stays 0, done pulses the next cycle, duty unchanged.
- Reset mid-ramp at duty=60 → duty=0 asynchronously (before next clk edge), busy=0, no done. After release, the period counter restarts from 0.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer for the pwm stage: ramps duty toward a loaded target in
// fixed steps, changing it only on pwm period boundaries.
module pwm_duty_ramp #(
    parameter int unsigned WIDTH            = 17,
    parameter int unsigned PERIOD           = 100000,
    parameter int unsigned STEP             = 1000,
    parameter int unsigned PERIODS_PER_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] target,
    input  logic             load,
    output logic [WIDTH-1:0] duty,
    output logic             period_tick,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned SW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [SW-1:0]    STEP_LAST = SW'(PERIODS_PER_STEP - 1);
    localparam logic [WIDTH-1:0] TGT_MAX   = WIDTH'(PERIOD);
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt, cnt_next;
    logic [SW-1:0]    step_cnt, step_next;
    logic [WIDTH-1:0] tgt, tgt_next, tgt_in;
    logic [WIDTH-1:0] duty_next, step_val;
    logic             busy_next, done_next;
    logic [WIDTH:0]   up_sum, down_diff;

    // Period counter; tick is registered so it is high while cnt == PERIOD-1.
    always_comb begin
        cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            period_tick <= (cnt_next == CNT_LAST);
        end
    end

    // Target clamp and step arithmetic, one bit wider so nothing wraps.
    always_comb begin
        tgt_in    = (target > TGT_MAX) ? TGT_MAX : target;
        up_sum    = {1'b0, duty} + STEP_W;
        down_diff = {1'b0, duty} - {1'b0, tgt};
        step_val  = duty;
        if (state == UP) begin
            step_val = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[WIDTH-1:0];
        end else if (state == DOWN) begin
            step_val = (down_diff <= STEP_W) ? tgt : duty - STEP_W[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load takes priority over a coincident period tick: no step that cycle.
    always_comb begin
        state_next = state;
        duty_next  = duty;
        tgt_next   = tgt;
        step_next  = step_cnt;
        busy_next  = busy;
        done_next  = 1'b0;
        if (load) begin
            tgt_next  = tgt_in;
            step_next = '0;
            if (tgt_in > duty) begin
                state_next = UP;
                busy_next  = 1'b1;
            end else if (tgt_in < duty) begin
                state_next = DOWN;
                busy_next  = 1'b1;
            end else begin
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end
        end else if (period_tick && (state != IDLE)) begin
            if (step_cnt == STEP_LAST) begin
                step_next = '0;
                duty_next = step_val;
                if (step_val == tgt) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end else begin
                step_next = step_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty     <= '0;
            tgt      <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            duty     <= duty_next;
            tgt      <= tgt_next;
            step_cnt <= step_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: vector table, hand-built corner sequences and a
// randomized run, all checked against an arithmetic model of the ramp rules.
module tb_pwm_duty_ramp;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 100;
    localparam int STEP   = 30;
    localparam int PPS    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] target;
    logic             load;
    logic [WIDTH-1:0] duty;
    logic             period_tick, busy, done;

    pwm_duty_ramp #(
        .WIDTH(WIDTH),
        .PERIOD(PERIOD),
        .STEP(STEP),
        .PERIODS_PER_STEP(PPS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .target(target),
        .load(load),
        .duty(duty),
        .period_tick(period_tick),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int dones = 0;

    // Reference model: edges since release, current duty, captured target,
    // ticks seen since the last load or step.
    int m_edges = 0;
    int m_duty  = 0;
    int m_tgt   = 0;
    int m_ticks = 0;
    int m_done  = 0;

    typedef struct {
        bit do_load;
        int target;
        int ticks;
        int exp_duty;
        int exp_busy;
        int exp_dones;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit ld, input int tg);
        bit tick_now;
        tick_now = (m_edges % PERIOD) == PERIOD - 1;
        m_done = 0;
        if (ld) begin
            m_tgt   = (tg > PERIOD) ? PERIOD : tg;
            m_ticks = 0;
            if (m_tgt == m_duty) m_done = 1;
        end else if (tick_now && m_duty != m_tgt) begin
            m_ticks++;
            if (m_ticks == PPS) begin
                m_ticks = 0;
                if (m_tgt > m_duty)
                    m_duty = (m_tgt - m_duty <= STEP) ? m_tgt : m_duty + STEP;
                else
                    m_duty = (m_duty - m_tgt <= STEP) ? m_tgt : m_duty - STEP;
                if (m_duty == m_tgt) m_done = 1;
            end
        end
        m_edges++;
    endtask

    task automatic step(input bit ld, input int tg);
        load   = ld;
        target = WIDTH'(tg);
        @(posedge clk);
        model_edge(ld, tg);
        #1;
        chk("duty", int'(duty), m_duty);
        chk("busy", int'(busy), int'(m_duty != m_tgt));
        chk("done", int'(done), m_done);
        chk("period_tick", int'(period_tick), int'((m_edges % PERIOD) == PERIOD - 1));
        dones += int'(done);
        load = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int guard = 0;
        while (seen < n && guard < (n + 1) * PERIOD) begin
            step(0, 0);
            guard++;
            if (period_tick) seen++;
        end
        chk("tick_timeout", seen, n);
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        m_duty = 0; m_tgt = 0; m_ticks = 0; m_done = 0; m_edges = 0;
        #1;
        chk("rst_duty", int'(duty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tick", int'(period_tick), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        dones = 0;
        if (v.do_load) step(1, v.target);
        if (v.ticks > 0) begin
            wait_ticks(v.ticks);
            step(0, 0);
        end
        chk($sformatf("vec%0d_duty", idx), int'(duty), v.exp_duty);
        chk($sformatf("vec%0d_busy", idx), int'(busy), v.exp_busy);
        chk($sformatf("vec%0d_dones", idx), dones, v.exp_dones);
    endtask

    initial begin
        int n;
        bit ld;

        tbl[0]  = '{1, 100, 0,   0, 1, 0};
        tbl[1]  = '{0,   0, 2,  30, 1, 0};
        tbl[2]  = '{0,   0, 2,  60, 1, 0};
        tbl[3]  = '{0,   0, 2,  90, 1, 0};
        tbl[4]  = '{0,   0, 2, 100, 0, 1};
        tbl[5]  = '{1,   0, 0, 100, 1, 0};
        tbl[6]  = '{0,   0, 2,  70, 1, 0};
        tbl[7]  = '{0,   0, 2,  40, 1, 0};
        tbl[8]  = '{0,   0, 2,  10, 1, 0};
        tbl[9]  = '{0,   0, 2,   0, 0, 1};
        tbl[10] = '{1, 150, 0,   0, 1, 0};
        tbl[11] = '{0,   0, 2,  30, 1, 0};
        tbl[12] = '{0,   0, 4,  90, 1, 0};
        tbl[13] = '{0,   0, 2, 100, 0, 1};
        tbl[14] = '{1, 100, 0, 100, 0, 1};

        rst_n  = 1'b0;
        load   = 1'b0;
        target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_duty", int'(duty), 0);
        chk("init_busy", int'(busy), 0);
        chk("init_done", int'(done), 0);
        chk("init_tick", int'(period_tick), 0);
        rst_n = 1'b1;

        // First tick lands 99 clocks after release.
        n = 0;
        while (n < 2 * PERIOD) begin
            step(0, 0);
            n++;
            if (period_tick) break;
        end
        chk("first_tick", n, PERIOD - 1);
        step(0, 0);

        for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

        // Load coincident with the tick that would have stepped 60 -> 90.
        do_reset();
        step(1, 100);
        wait_ticks(4);
        step(0, 0);
        chk("col_pre_duty", int'(duty), 60);
        wait_ticks(1);
        wait_ticks(1);
        step(1, 20);
        chk("col_hold_duty", int'(duty), 60);
        chk("col_hold_busy", int'(busy), 1);
        dones = 0;
        wait_ticks(2);
        step(0, 0);
        chk("col_down1", int'(duty), 30);
        wait_ticks(2);
        step(0, 0);
        chk("col_down2", int'(duty), 20);
        chk("col_dones", dones, 1);

        // No-op load of the current duty.
        step(1, 20);
        chk("noop_busy", int'(busy), 0);
        chk("noop_done", int'(done), 1);
        chk("noop_duty", int'(duty), 20);

        // Reset mid-ramp at duty 60, then period counter restarts.
        do_reset();
        step(1, 100);
        wait_ticks(4);
        repeat (5) step(0, 0);
        chk("mid_pre_duty", int'(duty), 60);
        do_reset();
        n = 0;
        dones = 0;
        while (n < 2 * PERIOD) begin
            step(0, 0);
            n++;
            if (period_tick) break;
        end
        chk("rel_first_tick", n, PERIOD - 1);
        chk("rel_no_done", dones, 0);

        for (int i = 0; i < 20000; i++) begin
            ld = ($urandom_range(0, 299) == 0) || (period_tick && $urandom_range(0, 9) == 0);
            step(ld, int'($urandom_range(0, 255)));
            if (i == 10000) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
